cram_wr_arb: RTL and testbench
==============================

Name: cram_wr_arb

Overview:
- Owns the single write port of the video colour RAM (CRAM, 256 x 16 palette; bit 15 = DAC mode, 14:0 = RGB555).
- Shares that port between three requesters:
  - the Z80 byte-wide palette window,
  - the DMA engine's 16-bit palette bursts,
  - an internal clear sequencer that fills all entries with one value.
- Drives the registered cram_addr / cram_data / cram_we consumed by the video output stage.

Parameters:
AW, 8, CRAM word address width (entries = 2**AW)
DW, 16, CRAM word width

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
cpu_wr  in  1  single-cycle Z80 write strobe to palette window
cpu_addr  in  AW+1  byte address; bit 0 = 0 low byte, 1 high byte
cpu_data  in  8  write byte
dma_req  in  1  DMA word write request; held until dma_ack
dma_addr  in  AW  DMA target entry
dma_data  in  DW  DMA word
dma_ack  out  1  one-cycle acknowledge, word written
clr_start  in  1  single-cycle pulse, start clear of whole CRAM
clr_value  in  DW  fill value, sampled at clr_start
clr_busy  out  1  high while clear sequencer active
cram_addr  out  AW  CRAM write address
cram_data  out  DW  CRAM write data
cram_we  out  1  CRAM write enable, one cycle per word

Behaviour:
Reset (rst_n low, async):
- cram_we=0, cram_addr=0, cram_data=0.
- dma_ack=0, clr_busy=0.
- Low-byte latch=0; clear FSM to IDLE; clear counter=0.
- A clear in progress is abandoned; no resume after reset.

CPU path:
- cpu_wr with cpu_addr[0]=0: latch cpu_data into lo_latch; no CRAM write.
- cpu_wr with cpu_addr[0]=1: commit. Cycle N strobe -> cycle N+1 cram_we=1, cram_addr=cpu_addr[AW:1], cram_data={cpu_data, lo_latch}.
- lo_latch is not cleared by a commit; repeated high-byte writes reuse it.
- Low byte and high byte written to different entries: legal, latch content used as is.

Priority per cycle, evaluated on sampled inputs:
- CPU commit > DMA > clear. Exactly one CRAM write per cycle at most.

DMA path:
- Granted in cycle N when dma_req=1, no CPU commit in N, and dma_ack=0 in N.
- Cycle N+1: cram_we=1 with dma_addr/dma_data, and dma_ack=1 for exactly that cycle.
- The cycle after an ack is never a DMA grant, so DMA throughput is at most 1 word / 2 cycles. The master updates req/addr/data in response to ack.
- A CPU commit delays a pending DMA grant; dma_req stays asserted, no data lost.

Clear FSM:
- States IDLE, FILL.
- IDLE -> FILL on clr_start: capture clr_value, counter=0, clr_busy=1 from next cycle.
- In FILL, each cycle with no CPU commit and no DMA grant:
  - cram_we=1 next cycle, cram_addr=counter, cram_data=captured value;
  - counter increments.
- After writing entry 2**AW-1: FILL -> IDLE, clr_busy=0 in the same cycle that last cram_we is high.
- clr_start while in FILL is ignored; the captured value is unchanged.
- CPU/DMA writes during FILL land normally. A later FILL write may overwrite them; software must wait for !clr_busy.
- Counter wraps only by termination; no second pass.

Idle outputs:
- cram_we=0 when no grant; cram_addr/cram_data hold their last values.

Decomposition:
- Shared package holds:
  - CRAM geometry constants (CRAM_AW=8, CRAM_DW=16);
  - bit-field constants (DAC mode bit 15, R 14:10, G 9:5, B 4:0);
  - clear FSM state encoding.
- One sub-module is natural: cram_clr_seq (FILL FSM + counter + captured value; interface stall in, wr_valid/addr/data out, busy out).
- The arbiter and CPU byte assembler stay in the top module.

Test Plan:
- Reset and write-back:
  - Stimulus: reset, then cpu_wr addr 0x000 data 0x34, then addr 0x001 data 0x12.
  - Required response: one cram_we, addr 0x00, data 0x1234; no write on the low byte.
- Simultaneous CPU and DMA:
  - Stimulus: cpu_wr addr 0x1FF data 0x80 (lo_latch 0x00) in the same cycle as dma_req addr 0x10 data 0x7FFF.
  - Required response: cycle N+1 writes 0xFF=0x8000; cycle N+2 writes 0x10=0x7FFF with dma_ack=1.
- DMA back-to-back burst:
  - Stimulus: 4 words to addr 0x20..0x23 with dma_req held high.
  - Required response: 4 acks spaced exactly 2 cycles apart; cram_we pattern 1010101; correct data per address.
- Full clear:
  - Stimulus: clr_start, clr_value 0x0421.
  - Required response: 256 writes addr 0x00..0xFF, all data 0x0421; clr_busy high for exactly 256 cycles when there is no contention; second clr_start mid-fill ignored.
- Clear under contention:
  - Stimulus: during FILL at counter 0x40, a CPU commit to 0x05 and a DMA word to 0x80.
  - Required response: the fill stalls 2 cycles; 0x05 is written by the CPU (not overwritten, already passed); 0x80 is later overwritten by the fill; total busy 258 cycles.
- Reset mid-operation:
  - Stimulus: rst_n low at counter 0x7F while dma_req is high.
  - Required response: cram_we, dma_ack and clr_busy are 0 immediately (async); after release there are no further fill writes, and the DMA is granted normally.

Source files
------------

// File: rtl/cram_wr_arb_pkg.sv
// Shared definitions for the CRAM write arbiter: geometry, palette fields, clear FSM states.
package cram_wr_arb_pkg;

  localparam int CRAM_AW = 8;
  localparam int CRAM_DW = 16;

  localparam int CRAM_DAC_BIT = 15;
  localparam int CRAM_R_HI    = 14;
  localparam int CRAM_R_LO    = 10;
  localparam int CRAM_G_HI    = 9;
  localparam int CRAM_G_LO    = 5;
  localparam int CRAM_B_HI    = 4;
  localparam int CRAM_B_LO    = 0;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_FILL = 1'b1
  } clr_state_e;

  function automatic logic [CRAM_DW-1:0] cram_pack(input logic dac, input logic [4:0] r,
                                                   input logic [4:0] g, input logic [4:0] b);
    logic [CRAM_DW-1:0] v;
    v = '0;
    v[CRAM_DAC_BIT]          = dac;
    v[CRAM_R_HI:CRAM_R_LO]   = r;
    v[CRAM_G_HI:CRAM_G_LO]   = g;
    v[CRAM_B_HI:CRAM_B_LO]   = b;
    return v;
  endfunction

endpackage

// File: rtl/cram_wr_arb_clr_seq.sv
// Clear sequencer: walks every CRAM entry once, writing a captured fill value.
// state    | meaning
// CLR_IDLE | waiting for i_start; no write request
// CLR_FILL | requesting a write of r_value at r_cnt; advances when not stalled
module cram_clr_seq
  import cram_wr_arb_pkg::*;
#(
  parameter int AW = CRAM_AW,
  parameter int DW = CRAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [DW-1:0] i_value,
  input  logic          i_stall,
  output logic          o_wr_valid,
  output logic [AW-1:0] o_wr_addr,
  output logic [DW-1:0] o_wr_data,
  output logic          o_busy
);

  clr_state_e    r_state;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLR_IDLE;
      r_cnt   <= '0;
      r_value <= '0;
    end else begin
      case (r_state)
        CLR_IDLE: begin
          if (i_start) begin
            r_state <= CLR_FILL;
            r_cnt   <= '0;
            r_value <= i_value;
          end
        end
        CLR_FILL: begin
          // Last entry granted: drop busy in the same cycle its write appears.
          if (!i_stall) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == {AW{1'b1}}) r_state <= CLR_IDLE;
          end
        end
        default: r_state <= CLR_IDLE;
      endcase
    end
  end

  assign o_wr_valid = (r_state == CLR_FILL);
  assign o_wr_addr  = r_cnt;
  assign o_wr_data  = r_value;
  assign o_busy     = (r_state == CLR_FILL);

endmodule

// File: rtl/cram_wr_arb.sv
// Single CRAM write port shared by Z80 byte window, DMA words and the clear sequencer.
// Fixed priority: CPU commit, then DMA, then clear; at most one registered write per cycle.
module cram_wr_arb
  import cram_wr_arb_pkg::*;
#(
  parameter int AW = CRAM_AW,
  parameter int DW = CRAM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_wr,
  input  logic [AW:0]   cpu_addr,
  input  logic [7:0]    cpu_data,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_data,
  output logic          dma_ack,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_value,
  output logic          clr_busy,
  output logic [AW-1:0] cram_addr,
  output logic [DW-1:0] cram_data,
  output logic          cram_we
);

  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_ack;
  logic [7:0]    r_lo_latch;

  logic          w_cpu_lo;
  logic          w_cpu_commit;
  logic          w_dma_grant;
  logic          w_clr_valid;
  logic          w_clr_grant;
  logic          w_clr_stall;
  logic [AW-1:0] w_clr_addr;
  logic [DW-1:0] w_clr_data;

  assign w_cpu_lo     = cpu_wr & ~cpu_addr[0];
  assign w_cpu_commit = cpu_wr &  cpu_addr[0];
  // A DMA grant is never issued in an ack cycle, so the master has a cycle to advance.
  assign w_dma_grant  = dma_req & ~w_cpu_commit & ~r_ack;
  assign w_clr_stall  = w_cpu_commit | w_dma_grant;
  assign w_clr_grant  = w_clr_valid & ~w_clr_stall;

  cram_clr_seq #(.AW(AW), .DW(DW)) u_clr_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (clr_start),
    .i_value    (clr_value),
    .i_stall    (w_clr_stall),
    .o_wr_valid (w_clr_valid),
    .o_wr_addr  (w_clr_addr),
    .o_wr_data  (w_clr_data),
    .o_busy     (clr_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_ack      <= 1'b0;
      r_lo_latch <= '0;
    end else begin
      r_we  <= w_cpu_commit | w_dma_grant | w_clr_grant;
      r_ack <= w_dma_grant;
      if (w_cpu_lo) r_lo_latch <= cpu_data;
      if (w_cpu_commit) begin
        r_addr <= cpu_addr[AW:1];
        r_data <= {cpu_data, r_lo_latch};
      end else if (w_dma_grant) begin
        r_addr <= dma_addr;
        r_data <= dma_data;
      end else if (w_clr_grant) begin
        r_addr <= w_clr_addr;
        r_data <= w_clr_data;
      end
    end
  end

  assign cram_we   = r_we;
  assign cram_addr = r_addr;
  assign cram_data = r_data;
  assign dma_ack   = r_ack;

endmodule

// File: tb/tb_cram_wr_arb.sv
// Directed bench for cram_wr_arb: CPU byte assembly, arbitration, DMA pacing, clear, reset.
module tb_cram_wr_arb;
  import cram_wr_arb_pkg::*;

  localparam int AW = CRAM_AW;
  localparam int DW = CRAM_DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_wr = 1'b0;
  logic [AW:0]   cpu_addr = '0;
  logic [7:0]    cpu_data = '0;
  logic          dma_req = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [DW-1:0] dma_data = '0;
  logic          dma_ack;
  logic          clr_start = 1'b0;
  logic [DW-1:0] clr_value = '0;
  logic          clr_busy;
  logic [AW-1:0] cram_addr;
  logic [DW-1:0] cram_data;
  logic          cram_we;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cram_wr_arb #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_wr    (cpu_wr),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .dma_req   (dma_req),
    .dma_addr  (dma_addr),
    .dma_data  (dma_data),
    .dma_ack   (dma_ack),
    .clr_start (clr_start),
    .clr_value (clr_value),
    .clr_busy  (clr_busy),
    .cram_addr (cram_addr),
    .cram_data (cram_data),
    .cram_we   (cram_we)
  );

  logic [AW+DW:0] w_obs;
  assign w_obs = {cram_we, cram_addr, cram_data};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_checks++;
    if (w_obs !== 25'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: we/addr/data got %h expected %h", w_obs, 25'h0);
    end
    n_checks++;
    if ({dma_ack, clr_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ack_busy: got %b expected 00", {dma_ack, clr_busy});
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_cpu_write;
    cpu_wr = 1'b1; cpu_addr = 9'h000; cpu_data = 8'h34;
    tick();
    n_checks++;
    if (cram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_lo_no_write: cram_we got %b expected 0", cram_we);
    end
    cpu_addr = 9'h001; cpu_data = 8'h12;
    tick();
    n_checks++;
    if (w_obs !== {1'b1, 8'h00, 16'h1234}) begin
      n_fail++;
      $display("FAIL cpu_commit: got %h expected %h", w_obs, {1'b1, 8'h00, 16'h1234});
    end
    cpu_addr = 9'h003; cpu_data = 8'h56;
    tick();
    n_checks++;
    if (w_obs !== {1'b1, 8'h01, 16'h5634}) begin
      n_fail++;
      $display("FAIL cpu_latch_reuse: got %h expected %h", w_obs, {1'b1, 8'h01, 16'h5634});
    end
    cpu_wr = 1'b0;
    tick();
    n_checks++;
    if (w_obs !== {1'b0, 8'h01, 16'h5634}) begin
      n_fail++;
      $display("FAIL idle_hold: got %h expected %h", w_obs, {1'b0, 8'h01, 16'h5634});
    end
  endtask

  task automatic test_cpu_dma_collision;
    cpu_wr = 1'b1; cpu_addr = 9'h000; cpu_data = 8'h00;
    tick();
    cpu_addr = 9'h1FF; cpu_data = 8'h80;
    dma_req = 1'b1; dma_addr = 8'h10; dma_data = 16'h7FFF;
    tick();
    n_checks++;
    if ({w_obs, dma_ack} !== {1'b1, 8'hFF, 16'h8000, 1'b0}) begin
      n_fail++;
      $display("FAIL collision_cpu_first: got %h ack %b expected %h ack 0", w_obs, dma_ack,
               {1'b1, 8'hFF, 16'h8000});
    end
    cpu_wr = 1'b0;
    tick();
    n_checks++;
    if ({w_obs, dma_ack} !== {1'b1, 8'h10, 16'h7FFF, 1'b1}) begin
      n_fail++;
      $display("FAIL collision_dma_second: got %h ack %b expected %h ack 1", w_obs, dma_ack,
               {1'b1, 8'h10, 16'h7FFF});
    end
    dma_req = 1'b0;
    tick();
    n_checks++;
    if ({cram_we, dma_ack} !== 2'b00) begin
      n_fail++;
      $display("FAIL collision_after: we/ack got %b expected 00", {cram_we, dma_ack});
    end
  endtask

  task automatic test_dma_burst;
    logic [15:0] exp_data [4];
    int w;
    exp_data[0] = 16'h0421; exp_data[1] = 16'h0842;
    exp_data[2] = 16'h0C63; exp_data[3] = 16'h1084;
    w = 0;
    dma_req  = 1'b1;
    dma_addr = 8'h20;
    dma_data = cram_pack(1'b0, 5'd1, 5'd1, 5'd1);
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k % 2 == 0) begin
        n_checks++;
        if ({w_obs, dma_ack} !== {1'b1, 8'h20 + 8'(w), exp_data[w], 1'b1}) begin
          n_fail++;
          $display("FAIL burst_word%0d: got %h ack %b expected %h ack 1", w, w_obs, dma_ack,
                   {1'b1, 8'h20 + 8'(w), exp_data[w]});
        end
        w++;
        if (w < 4) begin
          dma_addr = 8'h20 + 8'(w);
          dma_data = cram_pack(1'b0, 5'(w + 1), 5'(w + 1), 5'(w + 1));
        end else begin
          dma_req = 1'b0;
        end
      end else begin
        n_checks++;
        if ({cram_we, dma_ack} !== 2'b00) begin
          n_fail++;
          $display("FAIL burst_gap%0d: we/ack got %b expected 00", k, {cram_we, dma_ack});
        end
      end
    end
  endtask

  task automatic test_clear;
    int busy_cnt;
    busy_cnt  = 0;
    clr_value = 16'h0421;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    if (clr_busy === 1'b1) busy_cnt++;
    n_checks++;
    if ({cram_we, clr_busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL clear_start: we/busy got %b expected 01", {cram_we, clr_busy});
    end
    for (int i = 0; i < 256; i++) begin
      tick();
      clr_start = 1'b0;
      if (clr_busy === 1'b1) busy_cnt++;
      n_checks++;
      if (w_obs !== {1'b1, 8'(i), 16'h0421}) begin
        n_fail++;
        $display("FAIL clear_write%0d: got %h expected %h", i, w_obs, {1'b1, 8'(i), 16'h0421});
      end
      n_checks++;
      if (clr_busy !== (i != 255)) begin
        n_fail++;
        $display("FAIL clear_busy%0d: got %b expected %b", i, clr_busy, (i != 255));
      end
      if (i == 100) begin
        clr_start = 1'b1;
        clr_value = 16'hFFFF;
      end
    end
    tick();
    n_checks++;
    if ({cram_we, clr_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL clear_done: we/busy got %b expected 00", {cram_we, clr_busy});
    end
    n_checks++;
    if (busy_cnt !== 256) begin
      n_fail++;
      $display("FAIL clear_busy_len: got %0d expected 256", busy_cnt);
    end
  endtask

  task automatic test_clear_contention;
    int busy_cnt;
    busy_cnt = 0;
    cpu_wr = 1'b1; cpu_addr = 9'h00A; cpu_data = 8'hAA;
    tick();
    cpu_wr = 1'b0;
    clr_value = 16'h1111;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    if (clr_busy === 1'b1) busy_cnt++;
    for (int j = 0; j < 64; j++) begin
      tick();
      if (clr_busy === 1'b1) busy_cnt++;
      n_checks++;
      if (w_obs !== {1'b1, 8'(j), 16'h1111}) begin
        n_fail++;
        $display("FAIL cont_pre%0d: got %h expected %h", j, w_obs, {1'b1, 8'(j), 16'h1111});
      end
    end
    cpu_wr = 1'b1; cpu_addr = 9'h00B; cpu_data = 8'h55;
    dma_req = 1'b1; dma_addr = 8'h80; dma_data = 16'h2222;
    tick();
    if (clr_busy === 1'b1) busy_cnt++;
    cpu_wr = 1'b0;
    n_checks++;
    if (w_obs !== {1'b1, 8'h05, 16'h55AA}) begin
      n_fail++;
      $display("FAIL cont_cpu: got %h expected %h", w_obs, {1'b1, 8'h05, 16'h55AA});
    end
    tick();
    if (clr_busy === 1'b1) busy_cnt++;
    dma_req = 1'b0;
    n_checks++;
    if ({w_obs, dma_ack} !== {1'b1, 8'h80, 16'h2222, 1'b1}) begin
      n_fail++;
      $display("FAIL cont_dma: got %h ack %b expected %h ack 1", w_obs, dma_ack,
               {1'b1, 8'h80, 16'h2222});
    end
    for (int j = 64; j < 256; j++) begin
      tick();
      if (clr_busy === 1'b1) busy_cnt++;
      n_checks++;
      if (w_obs !== {1'b1, 8'(j), 16'h1111}) begin
        n_fail++;
        $display("FAIL cont_post%0d: got %h expected %h", j, w_obs, {1'b1, 8'(j), 16'h1111});
      end
    end
    n_checks++;
    if (busy_cnt !== 258) begin
      n_fail++;
      $display("FAIL cont_busy_len: got %0d expected 258", busy_cnt);
    end
  endtask

  task automatic test_reset_mid;
    clr_value = 16'h3333;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int j = 0; j < 127; j++) tick();
    n_checks++;
    if (w_obs !== {1'b1, 8'h7E, 16'h3333}) begin
      n_fail++;
      $display("FAIL rstmid_pre: got %h expected %h", w_obs, {1'b1, 8'h7E, 16'h3333});
    end
    dma_req = 1'b1; dma_addr = 8'h33; dma_data = 16'hBEEF;
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cram_we, dma_ack, clr_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_async: we/ack/busy got %b expected 000",
               {cram_we, dma_ack, clr_busy});
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({w_obs, dma_ack, clr_busy} !== {1'b1, 8'h33, 16'hBEEF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rstmid_dma: got %h ack %b busy %b expected %h ack 1 busy 0",
               w_obs, dma_ack, clr_busy, {1'b1, 8'h33, 16'hBEEF});
    end
    dma_req = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      n_checks++;
      if ({cram_we, clr_busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL rstmid_nofill%0d: we/busy got %b expected 00", j, {cram_we, clr_busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_dma_collision();
    test_dma_burst();
    test_clear();
    test_clear_contention();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
